add_round_key_sched: RTL and testbench

- AddRoundKey stage with an on-the-fly AES-128 key schedule; sits directly downstream of MixCol and XORs each round state with the matching round key.
- Holds one 128-bit round key register and advances it one round per accepted state, so no 11-entry key RAM is needed.
- Also serves round 0 (initial whitening) and round 10, which bypasses MixCol.

---
 rtl/add_round_key_sched_pkg.sv | 38 +++
 rtl/add_round_key_sched_aes_sbox.sv | 52 +++++
 rtl/add_round_key_sched.sv | 142 ++++++++++++++
 tb/tb_add_round_key_sched.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/add_round_key_sched_pkg.sv
// Shared AES-128 definitions for the AddRoundKey / key-schedule slice:
// round count, Rcon table, FSM encoding and byte/column geometry.
package add_round_key_sched_pkg;

    localparam int AES_NR = 10;

    localparam int BYTE_W = 8;
    localparam int COL_W  = 32;
    localparam int N_COLS = 4;
    localparam int BLK_W  = COL_W * N_COLS;

    localparam logic [7:0] AES_RCON [0:AES_NR-1] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READY = 2'd1,
        ST_DONE  = 2'd2
    } ark_state_e;

    // Rcon byte used when stepping the key from round cnt to round cnt+1.
    function automatic logic [7:0] rcon_for(input logic [3:0] cnt);
        logic [7:0] rc;
        rc = 8'h00;
        if (int'(cnt) < AES_NR) begin
            rc = AES_RCON[cnt];
        end
        return rc;
    endfunction

    // Row r of a column sits at bits [8r+7:8r]; row1 moves down to row0.
    function automatic logic [COL_W-1:0] rot_word(input logic [COL_W-1:0] w);
        return {w[BYTE_W-1:0], w[COL_W-1:BYTE_W]};
    endfunction

endpackage

// File: rtl/add_round_key_sched_aes_sbox.sv
// Combinational AES S-box: multiplicative inverse in GF(2^8) followed by
// the FIPS-197 affine transform. Shared with the SubBytes stage.
module aes_sbox
    import add_round_key_sched_pkg::*;
(
    input  logic [BYTE_W-1:0] sbox_in,
    output logic [BYTE_W-1:0] sbox_out
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ sh;
            end
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    // x^254 == x^-1 for nonzero x, and maps 0 to 0 as the S-box needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        return gf_mul(x252, x2);
    endfunction

    logic [7:0] inv_b;

    always_comb begin
        inv_b    = gf_inv(sbox_in);
        sbox_out = inv_b
                 ^ {inv_b[6:0], inv_b[7]}
                 ^ {inv_b[5:0], inv_b[7:6]}
                 ^ {inv_b[4:0], inv_b[7:5]}
                 ^ {inv_b[3:0], inv_b[7:4]}
                 ^ 8'h63;
    end

endmodule

// File: rtl/add_round_key_sched.sv
// AddRoundKey with an on-the-fly AES-128 key schedule (one key register,
// advanced per accepted state). Optional macro KEY_REWIND_EN rewinds the
// schedule to the cipher key after round 10 for back-to-back blocks.
module add_round_key_sched
    import add_round_key_sched_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [BLK_W-1:0]  Key_in,
    input  logic              Key_load,
    input  logic [BLK_W-1:0]  Data_in,
    input  logic              Data_valid,
    output logic              In_ready,
    output logic [BLK_W-1:0]  Data_out,
    output logic              Out_valid,
    output logic [3:0]        Round,
    output logic              Done
);

    localparam logic [3:0] LAST_RND = 4'(NR);

    ark_state_e state_q, state_d;
    logic [BLK_W-1:0] key_q, key_d;
    logic [BLK_W-1:0] data_out_q, data_out_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       round_q, round_d;
    logic             out_valid_q, out_valid_d;
    logic             done_q, done_d;
`ifdef KEY_REWIND_EN
    logic [BLK_W-1:0] cipher_q, cipher_d;
`endif

    logic             in_ready;
    logic             accept;

    logic [N_COLS-1:0][COL_W-1:0] w_cur;
    logic [N_COLS-1:0][COL_W-1:0] w_nxt;
    logic [COL_W-1:0] rot_w;
    logic [COL_W-1:0] sub_w;
    logic [COL_W-1:0] t_w;
    logic [BLK_W-1:0] next_key;

    assign w_cur = key_q;
    assign rot_w = rot_word(w_cur[N_COLS-1]);

    for (genvar i = 0; i < N_COLS; i++) begin : g_subword
        aes_sbox u_sbox (
            .sbox_in  (rot_w[BYTE_W*i +: BYTE_W]),
            .sbox_out (sub_w[BYTE_W*i +: BYTE_W])
        );
    end

    // Rcon lands on row 0 only, i.e. the low byte of the column.
    always_comb begin
        t_w      = sub_w ^ {{(COL_W-BYTE_W){1'b0}}, rcon_for(cnt_q)};
        w_nxt[0] = w_cur[0] ^ t_w;
        w_nxt[1] = w_cur[1] ^ w_nxt[0];
        w_nxt[2] = w_cur[2] ^ w_nxt[1];
        w_nxt[3] = w_cur[3] ^ w_nxt[2];
        next_key = w_nxt;
    end

    assign in_ready = (state_q == ST_READY) && !Key_load;
    assign accept   = Data_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        cnt_d       = cnt_q;
        data_out_d  = data_out_q;
        out_valid_d = 1'b0;
        round_d     = round_q;
`ifdef KEY_REWIND_EN
        done_d      = 1'b0;
        cipher_d    = cipher_q;
`else
        done_d      = done_q;
`endif

        if (Key_load) begin
            // Key_load wins over a same-cycle Data_valid; that data is dropped.
            key_d   = Key_in;
            cnt_d   = 4'd0;
            state_d = ST_READY;
            done_d  = 1'b0;
`ifdef KEY_REWIND_EN
            cipher_d = Key_in;
`endif
        end else if (accept) begin
            data_out_d  = Data_in ^ key_q;
            out_valid_d = 1'b1;
            round_d     = cnt_q;
            if (cnt_q == LAST_RND) begin
                done_d = 1'b1;
`ifdef KEY_REWIND_EN
                key_d  = cipher_q;
                cnt_d  = 4'd0;
`else
                state_d = ST_DONE;
`endif
            end else begin
                key_d = next_key;
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            key_q       <= '0;
            cnt_q       <= '0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
            round_q     <= '0;
            done_q      <= 1'b0;
`ifdef KEY_REWIND_EN
            cipher_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            cnt_q       <= cnt_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
            round_q     <= round_d;
            done_q      <= done_d;
`ifdef KEY_REWIND_EN
            cipher_q    <= cipher_d;
`endif
        end
    end

    assign In_ready  = in_ready;
    assign Data_out  = data_out_q;
    assign Out_valid = out_valid_q;
    assign Round     = round_q;
    assign Done      = done_q;

endmodule

// File: tb/tb_add_round_key_sched.sv
// Bench for add_round_key_sched: FIPS-197 known answers plus randomized
// traffic checked against a full-expansion (11 round key array) model.
module tb_add_round_key_sched;

    logic         CLK = 1'b0;
    logic         RST;
    logic [127:0] Key_in;
    logic         Key_load;
    logic [127:0] Data_in;
    logic         Data_valid;
    logic         In_ready;
    logic [127:0] Data_out;
    logic         Out_valid;
    logic [3:0]   Round;
    logic         Done;

    always #5 CLK = ~CLK;

    add_round_key_sched dut (
        .CLK        (CLK),
        .RST        (RST),
        .Key_in     (Key_in),
        .Key_load   (Key_load),
        .Data_in    (Data_in),
        .Data_valid (Data_valid),
        .In_ready   (In_ready),
        .Data_out   (Data_out),
        .Out_valid  (Out_valid),
        .Round      (Round),
        .Done       (Done)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]   sbox_tab [256];
    logic [127:0] m_rk [11];
    bit           m_ready;
    bit           m_done;
    bit           m_ov;
    int           m_idx;
    logic [127:0] m_out;
    logic [3:0]   m_round;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Inverse found by exhaustive search, then the bitwise affine formula.
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            for (int i = 0; i < 8; i++) begin
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            end
            sbox_tab[x] = s;
        end
    endtask

    // Spec-order hex (byte 0 written first) to the port layout (byte 0 at LSB).
    function automatic logic [127:0] from_fips(input logic [127:0] h);
        logic [127:0] v;
        for (int k = 0; k < 16; k++) v[8*k +: 8] = h[127-8*k -: 8];
        return v;
    endfunction

    // Textbook FIPS-197 expansion on big-endian words w[0..43].
    task automatic expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) begin
            w[i] = {key[32*i +: 8], key[32*i+8 +: 8], key[32*i+16 +: 8], key[32*i+24 +: 8]};
        end
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_tab[tmp[31:24]], sbox_tab[tmp[23:16]], sbox_tab[tmp[15:8]], sbox_tab[tmp[7:0]]};
                tmp = tmp ^ {rc, 24'h0};
                rc  = xtime(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r <= 10; r++) begin
            for (int c = 0; c < 4; c++) begin
                for (int j = 0; j < 4; j++) begin
                    m_rk[r][8*(4*c+j) +: 8] = w[4*r+c][31-8*j -: 8];
                end
            end
        end
    endtask

    task automatic do_reset();
        RST        = 1'b1;
        Key_load   = 1'b0;
        Data_valid = 1'b0;
        @(posedge CLK);
        #1;
        RST     = 1'b0;
        m_ready = 1'b0;
        m_done  = 1'b0;
        m_ov    = 1'b0;
        m_idx   = 0;
        m_out   = '0;
        m_round = 4'd0;
        chk("rst_in_ready",  128'(In_ready),  128'(1'b0));
        chk("rst_data_out",  Data_out,        128'h0);
        chk("rst_out_valid", 128'(Out_valid), 128'(1'b0));
        chk("rst_round",     128'(Round),     128'(4'd0));
        chk("rst_done",      128'(Done),      128'(1'b0));
    endtask

    task automatic step(input bit kl, input logic [127:0] key, input bit dv, input logic [127:0] data);
        bit exp_rdy;
        Key_load   = kl;
        Key_in     = key;
        Data_valid = dv;
        Data_in    = data;
        #1;
        exp_rdy = m_ready && !kl;
        chk("in_ready", 128'(In_ready), 128'(exp_rdy));
`ifdef KEY_REWIND_EN
        m_done = 1'b0;
`endif
        if (kl) begin
            expand(key);
            m_idx   = 0;
            m_ready = 1'b1;
            m_done  = 1'b0;
            m_ov    = 1'b0;
        end else if (dv && exp_rdy) begin
            m_out   = data ^ m_rk[m_idx];
            m_ov    = 1'b1;
            m_round = 4'(m_idx);
            if (m_idx == 10) begin
                m_done = 1'b1;
`ifdef KEY_REWIND_EN
                m_idx = 0;
`else
                m_ready = 1'b0;
`endif
            end else begin
                m_idx++;
            end
        end else begin
            m_ov = 1'b0;
        end
        @(posedge CLK);
        #1;
        chk("out_valid", 128'(Out_valid), 128'(m_ov));
        chk("data_out",  Data_out,        m_out);
        chk("round",     128'(Round),     128'(m_round));
        chk("done",      128'(Done),      128'(m_done));
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    logic [127:0] fips_key;
    logic [127:0] rkey;

    initial begin
        RST        = 1'b1;
        Key_load   = 1'b0;
        Key_in     = '0;
        Data_valid = 1'b0;
        Data_in    = '0;
        build_sbox();
        fips_key = from_fips(128'h2b7e151628aed2a6abf7158809cf4f3c);
        do_reset();

        // Data before any key is ignored.
        step(1'b0, '0, 1'b1, rnd128());

        // FIPS-197 round-0 whitening.
        step(1'b1, fips_key, 1'b0, '0);
        step(1'b0, '0, 1'b1, from_fips(128'h3243f6a8885a308d313198a2e0370734));
        chk("kat_r0", Data_out, from_fips(128'h193de3bea0f4e22b9ac68d2ae9f84808));

        // Zero data exposes the round keys; a 12th valid follows round 10.
        step(1'b1, fips_key, 1'b0, '0);
        for (int i = 0; i < 11; i++) begin
            step(1'b0, '0, 1'b1, '0);
            if (i == 1)  chk("kat_r1", Data_out, from_fips(128'ha0fafe1788542cb123a339392a6c7605));
            if (i == 10) begin
                chk("kat_r10", Data_out, from_fips(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
                chk("kat_done", 128'(Done), 128'(1'b1));
            end
        end
        step(1'b0, '0, 1'b1, '0);

        // Key_load and Data_valid together: data dropped, next accept is round 0.
        step(1'b1, fips_key, 1'b1, rnd128());
        step(1'b0, '0, 1'b1, rnd128());
        chk("kl_dv_round", 128'(Round), 128'(4'd0));

        // Valid on alternate cycles.
        rkey = rnd128();
        step(1'b1, rkey, 1'b0, '0);
        for (int i = 0; i < 24; i++) step(1'b0, '0, (i % 2) == 0, rnd128());

        // 22 back-to-back accepts (rewinds when the option is built in).
        step(1'b1, fips_key, 1'b0, '0);
        for (int i = 0; i < 22; i++) step(1'b0, '0, 1'b1, rnd128());

        // Reset after round 4; data ignored until a new Key_load.
        step(1'b1, rnd128(), 1'b0, '0);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, rnd128());
        do_reset();
        step(1'b0, '0, 1'b1, rnd128());
        step(1'b0, '0, 1'b1, rnd128());
        step(1'b1, rnd128(), 1'b0, '0);
        step(1'b0, '0, 1'b1, rnd128());

        // Randomized traffic with occasional reloads and resets.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 29) == 0, rnd128(), $urandom_range(0, 3) != 0, rnd128());
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
